// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, mul/div EX occupancy, CP0 flush.
// Optional HAZARD_PERF_CNT_EN adds saturating stall_cycles/flush_count performance counters.
module pipe_hazard_ctrl_chk #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 33
) (
  input logic clk
);
  // Flags unsupported occupancy parameters during simulation.
  always @(posedge clk) begin
    assert (MUL_CYCLES >= 2 && MUL_CYCLES <= 63) else $error("MUL_CYCLES out of range 2..63");
    assert (DIV_CYCLES >= 2 && DIV_CYCLES <= 63) else $error("DIV_CYCLES out of range 2..63");
  end
endmodule

module pipe_hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs_addr,
  input  logic [4:0] id_rt_addr,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic [4:0] ex_rd_waddr,
  input  logic       ex_rd_wena,
  input  logic       ex_is_load,
  input  logic       ex_mul_ena,
  input  logic       ex_div_ena,
  input  logic       exc_flush,
  output logic       pc_ena,
  output logic       if_id_ena,
  output logic       if_id_flush,
  output logic       id_ex_ena,
  output logic       id_ex_stall,
  output logic       ex_mem_bubble,
  output logic       md_busy,
  output logic       md_done
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [5:0] MUL_N = 6'(MUL_CYCLES);
  localparam logic [5:0] DIV_N = 6'(DIV_CYCLES);

  state_t     state_r;
  logic [5:0] cnt_r;
  logic [5:0] n_s;
  logic       md_start_s;
  logic       md_stall_s;
  logic       md_done_s;
  logic       load_use_s;
  logic       rs_hit_s;
  logic       rt_hit_s;
  logic       pc_ena_s;
  logic       if_id_ena_s;
  logic       if_id_flush_s;
  logic       id_ex_ena_s;
  logic       id_ex_stall_s;
  logic       ex_mem_bubble_s;

  pipe_hazard_ctrl_chk #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_chk (.clk(clk));

  assign n_s        = ex_mul_ena ? MUL_N : DIV_N;
  assign md_start_s = (state_r == IDLE) & (ex_mul_ena | ex_div_ena) & ~exc_flush;
  assign md_stall_s = md_start_s | ((state_r == BUSY) & (cnt_r > 6'd1));
  assign md_done_s  = (state_r == BUSY) & (cnt_r == 6'd1);
  assign rs_hit_s   = id_rs_used & (id_rs_addr == ex_rd_waddr);
  assign rt_hit_s   = id_rt_used & (id_rt_addr == ex_rd_waddr);
  assign load_use_s = ex_is_load & ex_rd_wena & (ex_rd_waddr != 5'd0) & (rs_hit_s | rt_hit_s);

  // Mul/div occupancy sequencer; an exception aborts any sequence in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 6'd0;
    end else if (exc_flush) begin
      state_r <= IDLE;
      cnt_r   <= 6'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (md_start_s) begin
            state_r <= BUSY;
            cnt_r   <= n_s - 6'd1;
          end
        end
        BUSY: begin
          cnt_r <= cnt_r - 6'd1;
          if (cnt_r == 6'd1) state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 6'd0;
        end
      endcase
    end
  end

  // Pipeline control priority: flush, then mul/div hold, then load-use bubble.
  always_comb begin
    pc_ena_s        = 1'b1;
    if_id_ena_s     = 1'b1;
    if_id_flush_s   = 1'b0;
    id_ex_ena_s     = 1'b1;
    id_ex_stall_s   = 1'b0;
    ex_mem_bubble_s = 1'b0;
    if (exc_flush) begin
      if_id_flush_s   = 1'b1;
      id_ex_stall_s   = 1'b1;
      ex_mem_bubble_s = 1'b1;
    end else if (md_stall_s) begin
      pc_ena_s        = 1'b0;
      if_id_ena_s     = 1'b0;
      id_ex_ena_s     = 1'b0;
      ex_mem_bubble_s = 1'b1;
    end else if (load_use_s) begin
      pc_ena_s      = 1'b0;
      if_id_ena_s   = 1'b0;
      id_ex_stall_s = 1'b1;
    end else begin
      pc_ena_s = 1'b1;
    end
  end

  assign pc_ena        = pc_ena_s;
  assign if_id_ena     = if_id_ena_s;
  assign if_id_flush   = if_id_flush_s;
  assign id_ex_ena     = id_ex_ena_s;
  assign id_ex_stall   = id_ex_stall_s;
  assign ex_mem_bubble = ex_mem_bubble_s;
  assign md_busy       = md_stall_s;
  assign md_done       = md_done_s;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_r;
  logic [31:0] flush_count_r;

  // Saturating counters of frozen-PC cycles and exception flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_r <= 32'd0;
      flush_count_r  <= 32'd0;
    end else begin
      if (!pc_ena_s && (stall_cycles_r != 32'hFFFF_FFFF)) stall_cycles_r <= stall_cycles_r + 32'd1;
      if (exc_flush && (flush_count_r != 32'hFFFF_FFFF)) flush_count_r <= flush_count_r + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_r;
  assign flush_count  = flush_count_r;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: expected control vectors are queued as stimulus is driven.
module tb_pipe_hazard_ctrl;

  // {pc_ena, if_id_ena, if_id_flush, id_ex_ena, id_ex_stall, ex_mem_bubble, md_busy, md_done}
  localparam logic [7:0] NORM    = 8'b1101_0000;
  localparam logic [7:0] LU      = 8'b0001_1000;
  localparam logic [7:0] MD      = 8'b0000_0110;
  localparam logic [7:0] DONE    = 8'b1101_0001;
  localparam logic [7:0] LU_DONE = 8'b0001_1001;
  localparam logic [7:0] FL_BUSY = 8'b1111_1110;
  localparam logic [7:0] FL_IDLE = 8'b1111_1100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs_addr = 5'd0, id_rt_addr = 5'd0, ex_rd_waddr = 5'd0;
  logic       id_rs_used = 1'b0, id_rt_used = 1'b0, ex_rd_wena = 1'b0, ex_is_load = 1'b0;
  logic       ex_mul_ena = 1'b0, ex_div_ena = 1'b0, exc_flush = 1'b0;
  logic       pc_ena, if_id_ena, if_id_flush, id_ex_ena, id_ex_stall, ex_mem_bubble, md_busy, md_done;
  logic [7:0] obs_v;
  logic [7:0] exp_v;
  logic [7:0] sb_q[$];
  int         vectors = 0;
  int         miscompares = 0;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  typedef struct {
    logic [4:0] rs, rt, wa;
    logic       rs_u, rt_u, we, ld;
    logic [7:0] exp;
  } lu_vec_t;
  lu_vec_t lu_tab[7];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(33)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .ex_rd_waddr(ex_rd_waddr), .ex_rd_wena(ex_rd_wena), .ex_is_load(ex_is_load),
    .ex_mul_ena(ex_mul_ena), .ex_div_ena(ex_div_ena), .exc_flush(exc_flush),
    .pc_ena(pc_ena), .if_id_ena(if_id_ena), .if_id_flush(if_id_flush),
    .id_ex_ena(id_ex_ena), .id_ex_stall(id_ex_stall), .ex_mem_bubble(ex_mem_bubble),
    .md_busy(md_busy), .md_done(md_done)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  assign obs_v = {pc_ena, if_id_ena, if_id_flush, id_ex_ena, id_ex_stall, ex_mem_bubble, md_busy, md_done};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_rs_addr = 5'd0; id_rt_addr = 5'd0; ex_rd_waddr = 5'd0;
    id_rs_used = 1'b0; id_rt_used = 1'b0; ex_rd_wena = 1'b0; ex_is_load = 1'b0;
    ex_mul_ena = 1'b0; ex_div_ena = 1'b0; exc_flush = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back(NORM);
      #1;
      exp_v = sb_q.pop_front();
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL reset[%0d]: got %b want %b", i, obs_v, exp_v);
      end
      tick();
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mul();
    ex_mul_ena = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) ex_mul_ena = 1'b0;
      sb_q.push_back(i < 4 ? MD : (i == 4 ? DONE : NORM));
      #1;
      exp_v = sb_q.pop_front();
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL mul cyc%0d: got %b want %b", i, obs_v, exp_v);
      end
      tick();
    end
`ifdef HAZARD_PERF_CNT_EN
    vectors++;
    if (stall_cycles !== 32'd3) begin
      miscompares++;
      $display("FAIL stall_cycles: got %0d want 3", stall_cycles);
    end
`endif
  endtask

  task automatic test_div_back_to_back();
    ex_div_ena = 1'b1;
    for (int i = 1; i <= 38; i++) begin
      if (i == 34) begin ex_div_ena = 1'b0; ex_mul_ena = 1'b1; end
      if (i == 38) ex_mul_ena = 1'b0;
      if (i <= 32)      sb_q.push_back(MD);
      else if (i == 33) sb_q.push_back(DONE);
      else if (i <= 36) sb_q.push_back(MD);
      else if (i == 37) sb_q.push_back(DONE);
      else              sb_q.push_back(NORM);
      #1;
      exp_v = sb_q.pop_front();
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL div_b2b cyc%0d: got %b want %b", i, obs_v, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_abort();
    ex_div_ena = 1'b1;
    for (int i = 1; i <= 27; i++) begin
      exc_flush = (i == 24 || i == 26);
      ex_div_ena = (i <= 24 || i == 26);
      if (i <= 23)      sb_q.push_back(MD);
      else if (i == 24) sb_q.push_back(FL_BUSY);
      else if (i == 26) sb_q.push_back(FL_IDLE);
      else              sb_q.push_back(NORM);
      #1;
      exp_v = sb_q.pop_front();
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL abort cyc%0d: got %b want %b", i, obs_v, exp_v);
      end
      tick();
    end
    clear_inputs();
`ifdef HAZARD_PERF_CNT_EN
    vectors++;
    if (flush_count !== 32'd2) begin
      miscompares++;
      $display("FAIL flush_count: got %0d want 2", flush_count);
    end
`endif
  endtask

  task automatic test_load_use();
    lu_tab[0] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, LU};
    lu_tab[1] = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, NORM};
    lu_tab[2] = '{5'd1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, LU};
    lu_tab[3] = '{5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, NORM};
    lu_tab[4] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, NORM};
    lu_tab[5] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, NORM};
    lu_tab[6] = '{5'd3, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, NORM};
    for (int i = 0; i < 7; i++) begin
      for (int c = 0; c < 2; c++) begin
        id_rs_addr = lu_tab[i].rs; id_rt_addr = lu_tab[i].rt; ex_rd_waddr = lu_tab[i].wa;
        id_rs_used = lu_tab[i].rs_u; id_rt_used = lu_tab[i].rt_u;
        ex_rd_wena = lu_tab[i].we;
        ex_is_load = (c == 0) ? lu_tab[i].ld : 1'b0;
        sb_q.push_back(c == 0 ? lu_tab[i].exp : NORM);
        #1;
        exp_v = sb_q.pop_front();
        vectors++;
        if (obs_v !== exp_v) begin
          miscompares++;
          $display("FAIL load_use[%0d] cyc%0d: got %b want %b", i, c, obs_v, exp_v);
        end
        tick();
      end
    end
    clear_inputs();
  endtask

  task automatic test_priority();
    id_rs_addr = 5'd5; id_rs_used = 1'b1; ex_rd_waddr = 5'd5; ex_rd_wena = 1'b1; ex_is_load = 1'b1;
    ex_mul_ena = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) clear_inputs();
      sb_q.push_back(i < 4 ? MD : (i == 4 ? LU_DONE : NORM));
      #1;
      exp_v = sb_q.pop_front();
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL priority cyc%0d: got %b want %b", i, obs_v, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    ex_div_ena = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      sb_q.push_back(MD);
      #1;
      exp_v = sb_q.pop_front();
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL async_rst busy cyc%0d: got %b want %b", i, obs_v, exp_v);
      end
      if (i < 14) tick();
    end
    clear_inputs();
    sb_q.push_back(MD);
    #1;
    exp_v = sb_q.pop_front();
    vectors++;
    if (obs_v !== exp_v) begin
      miscompares++;
      $display("FAIL async_rst hold: got %b want %b", obs_v, exp_v);
    end
    rst_n = 1'b0;
    sb_q.push_back(NORM);
    #1;
    exp_v = sb_q.pop_front();
    vectors++;
    if (obs_v !== exp_v) begin
      miscompares++;
      $display("FAIL async_rst edge-free: got %b want %b", obs_v, exp_v);
    end
    tick();
    rst_n = 1'b1;
    sb_q.push_back(NORM);
    #1;
    exp_v = sb_q.pop_front();
    vectors++;
    if (obs_v !== exp_v) begin
      miscompares++;
      $display("FAIL async_rst release: got %b want %b", obs_v, exp_v);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div_back_to_back();
    test_abort();
    test_priority();
    test_load_use();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
